pwm_multi_breathe: RTL and testbench
====================================

Name: pwm_multi_breathe

Overview:
Multi-channel PWM generator with one shared period counter and per-channel static or breathing (triangle-ramp) duty. Generalises the single-LED breathing PWM in width, channel count and mode. Duty changes are written through a valid/ready config port and applied glitch-free at period boundaries. Sits between the control/CSR logic and the board LED or driver pins.

Parameters:
CHANNELS, 4, number of PWM outputs (1..16)
PWM_W, 8, duty/counter width; period = 2^PWM_W clk cycles
RATE_W, 8, width of breathing step divider (periods per level step minus 1)

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high
enable  in  1  1 = outputs driven per duty; 0 = pwm_out forced low
cfg_valid  in  1  config write request
cfg_ready  out  1  config slot free
cfg_ch  in  max(1,$clog2(CHANNELS))  target channel
cfg_mode  in  1  0 = static duty, 1 = breathing
cfg_duty  in  PWM_W  static duty (mode 0) or breathing peak (mode 1)
cfg_rate  in  RATE_W  breathing step divider (ignored in mode 0)
pwm_out  out  CHANNELS  PWM outputs, registered
period_start  out  1  one-cycle pulse marking the first cycle of each period on pwm_out

Behaviour:
- Reset (reset high at a clk edge): pwm_cnt=0; every channel mode=0, duty=0, level=0, dir=up, prescaler=0; pending slot empty; pwm_out=0; period_start=0; cfg_ready=0 while reset high, 1 on the first cycle after.
- pwm_cnt increments every cycle, wraps 2^PWM_W-1 -> 0. It runs regardless of enable.
- Boundary cycle: the cycle where pwm_cnt == 2^PWM_W-1.
- Duty compare: eff[i] = duty[i] (mode 0) or level[i] (mode 1). The next-cycle pwm_out[i] = enable && (eff[i] > pwm_cnt), giving 1-cycle latency. Duty 0 = constant low. Duty 2^PWM_W-1 = high for 2^PWM_W-1 of 2^PWM_W cycles.
- period_start is registered as (pwm_cnt==0), so it is aligned with the pwm_out cycle that compares count 0.
- Config handshake:
  - A write is accepted when cfg_valid && cfg_ready. It is latched into the single pending slot, and cfg_ready drops the next cycle.
  - On the next boundary cycle edge, the pending entry is copied into the channel's active registers. For that channel: level=0, dir=up, prescaler=0. The slot is cleared and cfg_ready returns to 1 the following cycle.
  - The new duty is first visible on pwm_out in the cycle after period_start of the new period.
  - A write accepted in the boundary cycle itself is held until the NEXT boundary.
  - cfg_ch >= CHANNELS: the write is accepted and discarded at the boundary, with no channel changed.
- Breathing (mode 1), evaluated only at boundary edges, per channel:
  - If prescaler < rate: prescaler++.
  - Else: prescaler=0 and a level step occurs.
  - Step with dir=up: level++. When the new level == peak, dir becomes down.
  - Step with dir=down: level--. When the new level == 0, dir becomes up.
  - peak=0: level stays 0.
  - Result: the level changes every rate+1 periods, giving a triangle 0 -> peak -> 0 with a full cycle of 2*peak steps.
- enable=0 freezes all breathing prescalers and levels. Pending writes are still applied at boundaries.
- Reset mid-period or with a write pending: the pending write is discarded and full reset values apply.

Optional Feature:
PWM_PHASE_STAGGER_EN
- Defined: channel i compares against (pwm_cnt + i*2^PWM_W/CHANNELS) mod 2^PWM_W, integer division. This spreads rising edges to cut simultaneous switching current. The boundary, period_start and config timing still follow the unshifted pwm_cnt.
- Undefined: all channels compare against pwm_cnt, so rising edges are aligned at count 0.

Decomposition:
- Package pwm_pkg:
  - mode typedef (PWM_STATIC=0, PWM_BREATHE=1)
  - config struct {ch, mode, duty, rate}
  - helper constant for the channel-index width
- Sub-module pwm_breath_ch, one instance per channel, generated:
  - holds mode/duty/rate, level, dir and prescaler
  - inputs: boundary strobe, load strobe plus config, enable
  - output: eff duty
- Top level holds pwm_cnt, the pending slot/handshake, the comparators and the output registers.

Test Plan:
All scenarios run with CHANNELS=4, PWM_W=4, RATE_W=4.
- Reset then idle: after deassertion pwm_out=0000, period_start pulses every 16 cycles, cfg_ready=1.
- Static write ch1 duty=5 mid-period: cfg_ready low until the boundary. From the next period, pwm_out[1] is high exactly 5 of 16 cycles, starting with the period_start cycle. Other channels stay low.
- Duty extremes: ch0 duty=0 gives constant 0. ch0 duty=15 gives 15 high cycles and 1 low cycle (count 15) per period.
- Breathing ch2 peak=3 rate=1: level sequence per period from load is 0,0,1,1,2,2,3,3,2,2,1,1,0,0,1... Check the per-period high-count against it.
- Write accepted on the boundary cycle: it is not applied at that boundary, and is applied one period later. A second cfg_valid while the slot is full is not accepted until cfg_ready=1.
- enable=0 for 3 periods during breathing: pwm_out=0 and level frozen. On re-enable the ramp resumes from the frozen level. Assert reset with a write pending: the write is lost and all outputs are 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel breathing PWM block.
// Holds the channel mode/direction encodings and the channel-index width helper.
package pwm_pkg;

    typedef enum logic {
        PWM_STATIC  = 1'b0,
        PWM_BREATHE = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned ch_idx_w(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/pwm_breath_ch.sv
// One PWM channel's duty source: a static duty or a triangle ramp that
// steps once every (rate+1) periods between 0 and the programmed peak.
module pwm_breath_ch
    import pwm_pkg::*;
#(
    parameter int unsigned PWM_W  = 8,
    parameter int unsigned RATE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              boundary,
    input  logic              enable,
    input  logic              load,
    input  pwm_mode_e         load_mode,
    input  logic [PWM_W-1:0]  load_duty,
    input  logic [RATE_W-1:0] load_rate,
    output logic [PWM_W-1:0]  eff
);

    pwm_mode_e         mode;
    pwm_dir_e          dir;
    logic [PWM_W-1:0]  duty;
    logic [PWM_W-1:0]  level;
    logic [RATE_W-1:0] rate;
    logic [RATE_W-1:0] presc;
    logic [PWM_W-1:0]  level_inc;
    logic [PWM_W-1:0]  level_dec;

    // Neighbouring ramp levels used by the step logic.
    always_comb begin
        level_inc = level + 1'b1;
        level_dec = level - 1'b1;
    end

    // Config load and per-period ramp stepping; ramp is frozen while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode  <= PWM_STATIC;
            dir   <= DIR_UP;
            duty  <= '0;
            level <= '0;
            rate  <= '0;
            presc <= '0;
        end else if (load) begin
            mode  <= load_mode;
            duty  <= load_duty;
            rate  <= load_rate;
            dir   <= DIR_UP;
            level <= '0;
            presc <= '0;
        end else if (boundary && enable && (mode == PWM_BREATHE)) begin
            if (presc < rate) begin
                presc <= presc + 1'b1;
            end else begin
                presc <= '0;
                if (duty == '0) begin
                    level <= '0;
                end else if (dir == DIR_UP) begin
                    level <= level_inc;
                    if (level_inc == duty) dir <= DIR_DOWN;
                end else begin
                    level <= level_dec;
                    if (level_dec == '0) dir <= DIR_UP;
                end
            end
        end
    end

    // Effective duty seen by the comparator.
    always_comb begin
        eff = (mode == PWM_BREATHE) ? level : duty;
    end

endmodule

// File: rtl/pwm_multi_breathe.sv
// Multi-channel PWM with a shared period counter, a single pending config
// slot applied at period boundaries, and per-channel static/breathing duty.
// Build option: define PWM_PHASE_STAGGER_EN to offset each channel's compare
// count by i*2^PWM_W/CHANNELS, spreading rising edges across the period.
module pwm_multi_breathe
    import pwm_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PWM_W    = 8,
    parameter int unsigned RATE_W   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [ch_idx_w(CHANNELS)-1:0]   cfg_ch,
    input  logic                            cfg_mode,
    input  logic [PWM_W-1:0]                cfg_duty,
    input  logic [RATE_W-1:0]               cfg_rate,
    output logic [CHANNELS-1:0]             pwm_out,
    output logic                            period_start
);

    localparam int unsigned CH_W = ch_idx_w(CHANNELS);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        pwm_mode_e         mode;
        logic [PWM_W-1:0]  duty;
        logic [RATE_W-1:0] rate;
    } pwm_cfg_t;

    logic [PWM_W-1:0]    pwm_cnt;
    logic                boundary;
    logic                accept;
    logic                pend_valid;
    pwm_cfg_t            pend;
    logic [CHANNELS-1:0] load;
    logic [CHANNELS-1:0] pwm_next;
    logic [PWM_W-1:0]    eff [CHANNELS];

    // Period position and handshake decode.
    always_comb begin
        boundary  = (pwm_cnt == '1);
        cfg_ready = !reset && !pend_valid;
        accept    = cfg_valid && cfg_ready;
    end

    // Free-running period counter, independent of enable.
    always_ff @(posedge clk) begin
        if (reset) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Single pending slot: filled on accept, drained at the boundary edge.
    // A write accepted on the boundary cycle finds the slot empty there, so it
    // naturally waits for the following boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend       <= '0;
        end else if (boundary && pend_valid) begin
            pend_valid <= 1'b0;
        end else if (accept) begin
            pend_valid <= 1'b1;
            pend.ch    <= cfg_ch;
            pend.mode  <= pwm_mode_e'(cfg_mode);
            pend.duty  <= cfg_duty;
            pend.rate  <= cfg_rate;
        end
    end

    // Route the pending entry to its channel; out-of-range indices match none.
    always_comb begin
        load = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            load[i] = boundary && pend_valid && (pend.ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_breath_ch #(
            .PWM_W  (PWM_W),
            .RATE_W (RATE_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .boundary  (boundary),
            .enable    (enable),
            .load      (load[g]),
            .load_mode (pend.mode),
            .load_duty (pend.duty),
            .load_rate (pend.rate),
            .eff       (eff[g])
        );
    end

    // Duty comparators, optionally against a per-channel phase-shifted count.
    always_comb begin
        logic [PWM_W-1:0] cmp;
        pwm_next = '0;
        cmp      = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
`ifdef PWM_PHASE_STAGGER_EN
            cmp = pwm_cnt + PWM_W'((i * (2 ** PWM_W)) / CHANNELS);
`else
            cmp = pwm_cnt;
`endif
            pwm_next[i] = enable && (eff[i] > cmp);
        end
    end

    // Registered outputs; period_start lines up with the count-0 output cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= pwm_next;
            period_start <= (pwm_cnt == '0);
        end
    end

endmodule

// File: tb/tb_pwm_multi_breathe.sv
// Directed bench for pwm_multi_breathe with CHANNELS=4, PWM_W=4, RATE_W=4.
module tb_pwm_multi_breathe;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic       cfg_mode;
    logic [3:0] cfg_duty;
    logic [3:0] cfg_rate;
    logic [3:0] pwm_out;
    logic       period_start;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_multi_breathe #(
        .CHANNELS (4),
        .PWM_W    (4),
        .RATE_W   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_mode     (cfg_mode),
        .cfg_duty     (cfg_duty),
        .cfg_rate     (cfg_rate),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dmask(input int d);
        logic [16:0] t;
        t = (17'd1 << d) - 17'd1;
        return t[15:0];
    endfunction

    // Advance (bounded) to a negedge where period_start is high.
    task automatic wait_ps();
        int t = 0;
        while (period_start !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) check("ps_timeout", {31'd0, period_start}, 32'd1);
    endtask

    // Record one full period per channel; bit k = output in k-th cycle from period_start.
    task automatic capture(output logic [3:0][15:0] m);
        wait_ps();
        m = '0;
        for (int k = 0; k < 16; k++) begin
            for (int c = 0; c < 4; c++) m[c][k] = pwm_out[c];
            @(negedge clk);
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic mode,
                             input logic [3:0] duty, input logic [3:0] rate);
        int t = 0;
        while (cfg_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) check("ready_timeout", {31'd0, cfg_ready}, 32'd1);
        cfg_ch    = ch;
        cfg_mode  = mode;
        cfg_duty  = duty;
        cfg_rate  = rate;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("ready_drop", {31'd0, cfg_ready}, 32'd0);
    endtask

    initial begin
        logic [3:0][15:0] m;
        int ps_cnt;
        int lv [15];
        lv = '{0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0, 0, 1};

        reset = 1'b1; enable = 1'b1; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_mode = 1'b0; cfg_duty = '0; cfg_rate = '0;
        repeat (3) @(negedge clk);
        check("rst_pwm", pwm_out, 0);
        check("rst_ps", period_start, 0);
        check("rst_ready", cfg_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", cfg_ready, 1);
        check("post_rst_pwm", pwm_out, 0);

        // Idle: period_start every 16 cycles, outputs low.
        wait_ps();
        ps_cnt = 0;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            ps_cnt += int'(period_start);
        end
        @(negedge clk);
        check("ps_gap", ps_cnt, 0);
        check("ps_period", period_start, 1);
        capture(m);
        check("idle_pwm", {16'd0, m[0] | m[1] | m[2] | m[3]}, 0);

        // Static ch1 duty 5 written mid-period.
        repeat (5) @(negedge clk);
        cfg_write(2'd1, 1'b0, 4'd5, 4'd0);
        repeat (3) @(negedge clk);
        check("ready_held", cfg_ready, 0);
        capture(m);
        check("s5_ch1", m[1], 16'h001F);
        check("s5_ch0", m[0], 0);
        check("s5_ch23", {m[3], m[2]}, 0);
        check("ready_back", cfg_ready, 1);

        // Duty extremes on ch0.
        cfg_write(2'd0, 1'b0, 4'd15, 4'd0);
        capture(m);
        check("d15_ch0", m[0], 16'h7FFF);
        check("d15_ch1", m[1], 16'h001F);
        cfg_write(2'd0, 1'b0, 4'd0, 4'd0);
        capture(m);
        check("d0_ch0", m[0], 0);

        // Breathing ch2 peak 3 rate 1.
        cfg_write(2'd2, 1'b1, 4'd3, 4'd1);
        for (int p = 0; p < 15; p++) begin
            capture(m);
            check($sformatf("breathe_p%0d", p), m[2], dmask(lv[p]));
        end

        // Write accepted on the boundary cycle, then a second write while full.
        repeat (14) @(negedge clk);
        check("bnd_ready_pre", cfg_ready, 1);
        cfg_ch = 2'd3; cfg_mode = 1'b0; cfg_duty = 4'd7; cfg_rate = '0;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_duty = 4'd2;
        check("bnd_ready", cfg_ready, 0);
        capture(m);
        check("bnd_not_applied", m[3], 0);
        check("second_pending", cfg_ready, 0);
        cfg_valid = 1'b0;
        capture(m);
        check("bnd_applied", m[3], 16'h007F);
        capture(m);
        check("second_applied", m[3], 16'h0003);

        // Breathing with a disabled stretch in the middle.
        cfg_write(2'd2, 1'b1, 4'd3, 4'd1);
        for (int p = 0; p < 3; p++) begin
            capture(m);
            check($sformatf("pre_dis_p%0d", p), m[2], dmask(lv[p]));
        end
        enable = 1'b0;
        cfg_write(2'd1, 1'b0, 4'd9, 4'd0);
        for (int p = 0; p < 3; p++) begin
            capture(m);
            check($sformatf("dis_p%0d", p), {16'd0, m[0] | m[1] | m[2] | m[3]}, 0);
        end
        enable = 1'b1;
        @(negedge clk);
        capture(m);
        check("reen_p0", m[2], 16'h0003);
        check("dis_write_ch1", m[1], 16'h01FF);
        capture(m);
        check("reen_p1", m[2], 16'h0003);
        capture(m);
        check("reen_p2", m[2], 16'h0007);

        // Reset with a write pending.
        repeat (4) @(negedge clk);
        cfg_write(2'd0, 1'b0, 4'd15, 4'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst2_pwm", pwm_out, 0);
        check("rst2_ready", cfg_ready, 0);
        reset = 1'b0;
        capture(m);
        check("rst2_period", {16'd0, m[0] | m[1] | m[2] | m[3]}, 0);
        check("rst2_ready_after", cfg_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
